// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences register read/write commands from the UART RX FIFO onto the register file bus.
// Define UART_CTRL_TIMEOUT_EN to bound the wait for a write data byte to TIMEOUT_CYCLES clocks.
module uart_cmd_ctrl #(
  parameter int                    ADDR_W         = 3,
  parameter logic [(1<<ADDR_W)-1:0] WR_MASK       = 8'b0000_1101,
  parameter logic [(1<<ADDR_W)-1:0] RD_MASK       = 8'b0111_0011,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_fifo_e,
  output logic              o_rx_rd,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wr,
  input  logic              i_tx_fifo_f,
  output logic [ADDR_W-1:0] o_rwaddr,
  output logic [7:0]        o_write_data,
  output logic              o_wr_req,
  output logic              o_rd_req,
  input  logic [7:0]        i_read_data,
  output logic              o_busy,
  output logic              o_cmd_err
);
  typedef enum logic [2:0] {S_IDLE, S_GET_DATA, S_WRITE, S_READ, S_WAIT_RD, S_PUSH} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data, r_rd_byte;
  logic              r_cmd_err;
  logic              w_pop, w_err, w_hdr_ok, w_legal_wr, w_legal_rd, w_timeout;
  assign w_hdr_ok   = i_rx_data[6:ADDR_W] == '0;
  assign w_legal_wr = w_hdr_ok & i_rx_data[7] & WR_MASK[i_rx_data[ADDR_W-1:0]];
  assign w_legal_rd = w_hdr_ok & ~i_rx_data[7] & RD_MASK[i_rx_data[ADDR_W-1:0]];
`ifdef UART_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  // Held at zero outside GET_DATA so every entry starts a fresh count; saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (r_state != S_GET_DATA) r_cnt <= '0;
    else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + 1'b1;
  assign w_timeout = (r_state == S_GET_DATA) & i_rx_fifo_e & (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES != 0;
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: if (!i_rx_fifo_e) begin
        w_pop  = 1'b1;
        w_next = w_legal_wr ? S_GET_DATA : w_legal_rd ? S_READ : S_IDLE;
        w_err  = ~(w_legal_wr | w_legal_rd);
      end
      S_GET_DATA: if (!i_rx_fifo_e) begin
        w_pop  = 1'b1;
        w_next = S_WRITE;
      end else if (w_timeout) begin
        w_next = S_IDLE;
        w_err  = 1'b1;
      end
      S_WRITE:   w_next = S_IDLE;
      S_READ:    w_next = S_WAIT_RD;
      S_WAIT_RD: w_next = S_PUSH;
      S_PUSH:    w_next = i_tx_fifo_f ? S_PUSH : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_byte <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cmd_err <= w_err;
      if (w_pop && r_state == S_IDLE) r_addr <= i_rx_data[ADDR_W-1:0];
      if (w_pop && r_state == S_GET_DATA) r_data <= i_rx_data;
      if (r_state == S_WAIT_RD) r_rd_byte <= i_read_data;
    end
  // Pop is gated by reset so a non-empty FIFO is never consumed while held in reset.
  assign o_rx_rd      = w_pop & i_rst_n;
  assign o_wr_req     = r_state == S_WRITE;
  assign o_rd_req     = r_state == S_READ;
  assign o_tx_wr      = (r_state == S_PUSH) & ~i_tx_fifo_f;
  assign o_tx_data    = r_rd_byte;
  assign o_rwaddr     = r_addr;
  assign o_write_data = r_data;
  assign o_busy       = r_state != S_IDLE;
  assign o_cmd_err    = r_cmd_err;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: FIFO/register-file models around uart_cmd_ctrl, checked against a command-stream parser.
module tb_uart_cmd_ctrl;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst_n = 0, rx_e = 1, tx_full = 0;
  logic [7:0] rx_data = 0, rd_data = 0;
  logic rx_rd, tx_wr, wr_req, rd_req, busy, cmd_err;
  logic [7:0] tx_data, write_data;
  logic [2:0] rwaddr;
  bq_t rx_q, src_q, tx_q, exp_tx;
  logic [10:0] wr_q[$], exp_wr[$];
  logic [2:0] rd_q[$], exp_rd[$];
  int pop_cyc[$], wr_cyc[$], rd_cyc[$], tx_cyc[$];
  int n_chk = 0, n_fail = 0, n_err, exp_err, n_overlap, n_badpop, n_badpush, cyc = 0, err_cyc;
  bit gap_en = 0, full_rnd = 0;
  logic [7:0] rf[8];
  logic [7:0] wr_mask = 8'b0000_1101, rd_mask = 8'b0111_0011;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_fifo_e(rx_e), .o_rx_rd(rx_rd),
    .o_tx_data(tx_data), .o_tx_wr(tx_wr), .i_tx_fifo_f(tx_full), .o_rwaddr(rwaddr),
    .o_write_data(write_data), .o_wr_req(wr_req), .o_rd_req(rd_req), .i_read_data(rd_data),
    .o_busy(busy), .o_cmd_err(cmd_err));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic upd_rx();
    rx_e = rx_q.size() == 0;
    rx_data = rx_e ? 8'h00 : rx_q[0];
  endtask

  task automatic tick();
    logic p, r;
    logic [2:0] a;
    @(negedge clk);
    p = rx_rd; r = rd_req; a = rwaddr;
    if (wr_req && rd_req) n_overlap++;
    if (rx_rd && rx_q.size() == 0) n_badpop++;
    if (tx_wr && tx_full) n_badpush++;
    if (rx_rd) pop_cyc.push_back(cyc);
    if (wr_req) begin wr_q.push_back({rwaddr, write_data}); wr_cyc.push_back(cyc); end
    if (rd_req) begin rd_q.push_back(rwaddr); rd_cyc.push_back(cyc); end
    if (tx_wr) begin tx_q.push_back(tx_data); tx_cyc.push_back(cyc); end
    if (cmd_err) begin n_err++; err_cyc = cyc; end
    @(posedge clk);
    #1;
    cyc++;
    if (p && rx_q.size() != 0) rx_q.delete(0);
    if (src_q.size() != 0 && (!gap_en || $urandom_range(1, 0) == 1)) rx_q.push_back(src_q.pop_front());
    rd_data = r ? rf[a] : 8'($urandom);
    if (full_rnd) tx_full = $urandom_range(3, 0) == 0;
    upd_rx();
  endtask

  task automatic clear();
    rx_q.delete(); src_q.delete(); tx_q.delete(); wr_q.delete(); rd_q.delete();
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
    pop_cyc.delete(); wr_cyc.delete(); rd_cyc.delete(); tx_cyc.delete();
    n_err = 0; exp_err = 0; n_overlap = 0; n_badpop = 0; n_badpush = 0;
    upd_rx();
  endtask

  // Parses the byte stream by the command rules and lists the bus activity it should cause.
  task automatic build_model(input bq_t s);
    int i = 0;
    logic [7:0] b;
    while (i < s.size()) begin
      b = s[i];
      if (b[6:3] == 4'h0 && b[7] && wr_mask[b[2:0]] && i + 1 < s.size()) begin
        exp_wr.push_back({b[2:0], s[i+1]});
        i += 2;
      end else if (b[6:3] == 4'h0 && !b[7] && rd_mask[b[2:0]]) begin
        exp_rd.push_back(b[2:0]);
        exp_tx.push_back(rf[b[2:0]]);
        i++;
      end else begin
        exp_err++;
        i++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_q.size() != 0 || src_q.size() != 0 || busy) && n < 20000) begin
      tick();
      n++;
    end
    check("drain_budget", n < 20000, 1);
    tick();
    tick();
  endtask

  task automatic compare();
    check("wr_n", wr_q.size(), exp_wr.size());
    foreach (exp_wr[i]) if (i < wr_q.size()) check("wr", wr_q[i], exp_wr[i]);
    check("rd_n", rd_q.size(), exp_rd.size());
    foreach (exp_rd[i]) if (i < rd_q.size()) check("rd_addr", rd_q[i], exp_rd[i]);
    check("tx_n", tx_q.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_data", tx_q[i], exp_tx[i]);
    check("err_n", n_err, exp_err);
    check("overlap", n_overlap, 0);
    check("bad_pop", n_badpop, 0);
    check("bad_push", n_badpush, 0);
  endtask

  task automatic run(input bq_t s, input bit gaps);
    clear();
    build_model(s);
    gap_en = gaps;
    if (gaps) src_q = s;
    else rx_q = s;
    upd_rx();
    drain();
    compare();
  endtask

  initial begin
    bq_t s;
    logic [7:0] b;
    int n, lat;
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    rf[1] = 8'hA5;
    rst_n = 0;
    upd_rx();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_rd", rx_rd, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cmd_err, 0);
    check("rst_addr", rwaddr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_txdata", tx_data, 0);
    rx_q.push_back(8'h80);
    upd_rx();
    #1;
    check("rst_no_pop", rx_rd, 0);
    rx_q.delete();
    upd_rx();
    rst_n = 1;
    tick();
    tick();

    run('{8'h80, 8'h05}, 0);
    check("wr_lat_cmd", (pop_cyc.size() > 1 && wr_cyc.size() > 0) ? wr_cyc[0] - pop_cyc[0] : -1, 2);
    check("wr_lat_data", (pop_cyc.size() > 1 && wr_cyc.size() > 0) ? wr_cyc[0] - pop_cyc[1] : -1, 1);

    run('{8'h01}, 0);
    check("rd_lat", (pop_cyc.size() > 0 && rd_cyc.size() > 0) ? rd_cyc[0] - pop_cyc[0] : -1, 1);
    check("tx_lat", (rd_cyc.size() > 0 && tx_cyc.size() > 0) ? tx_cyc[0] - rd_cyc[0] : -1, 2);

    run('{8'h81, 8'h02, 8'h48}, 0);
    check("illegal_busy", busy, 0);

    clear();
    build_model('{8'h04});
    tx_full = 1;
    rx_q.push_back(8'h04);
    upd_rx();
    n = 0;
    while (pop_cyc.size() == 0 && n < 20) begin tick(); n++; end
    repeat (12) tick();
    check("full_hold", tx_q.size(), 0);
    check("full_busy", busy, 1);
    tx_full = 0;
    drain();
    compare();
    check("full_lat", (tx_cyc.size() > 0 && pop_cyc.size() > 0) ? tx_cyc[0] - pop_cyc[0] : -1, 13);

    clear();
    build_model('{8'h82, 8'h5A, 8'h83, 8'h33});
    rx_q = '{8'h82, 8'h5A, 8'h83};
    upd_rx();
    repeat (10) tick();
    check("gd_first_wr", wr_q.size(), 1);
    check("gd_waiting", busy, 1);
    rx_q.push_back(8'h33);
    upd_rx();
    drain();
    compare();

`ifdef UART_CTRL_TIMEOUT_EN
    clear();
    rx_q.push_back(8'h82);
    upd_rx();
    n = 0;
    while (pop_cyc.size() == 0 && n < 20) begin tick(); n++; end
    n = 0;
    while (n_err == 0 && n < 60) begin tick(); n++; end
    check("to_err", n_err, 1);
    lat = (pop_cyc.size() > 0) ? err_cyc - pop_cyc[0] : -1;
    check("to_lat", lat >= 17 && lat <= 18, 1);
    check("to_no_wr", wr_q.size(), 0);
    check("to_idle", busy, 0);
`endif

    clear();
    rx_q.push_back(8'h82);
    upd_rx();
    tick();
    tick();
    check("mid_busy", busy, 1);
    #1 rst_n = 0;
    #1;
    check("mid_busy_rst", busy, 0);
    check("mid_wr_req", wr_req, 0);
    check("mid_rd_req", rd_req, 0);
    check("mid_tx_wr", tx_wr, 0);
    check("mid_rx_rd", rx_rd, 0);
    check("mid_addr", rwaddr, 0);
    tick();
    rst_n = 1;
    repeat (3) tick();
    check("mid_no_wr", wr_q.size(), 0);

    s.delete();
    repeat (300) begin
      n = $urandom_range(3, 0);
      b = n == 0 ? {5'b10000, 3'($urandom)} : n == 1 ? {5'b00000, 3'($urandom)} : 8'($urandom);
      s.push_back(b);
      if (b[7] && b[6:3] == 4'h0 && wr_mask[b[2:0]]) s.push_back(8'($urandom));
    end
    full_rnd = 1;
    run(s, 1);
    full_rnd = 0;
    tx_full = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end
endmodule
